osc_phase_reader: RTL and testbench

Readout block for the coupled-oscillator Ising array: samples N free-running oscillator outputs against oscillator 0 (the phase reference) over a fixed measurement window and decodes each oscillator's binary spin from its in-phase/anti-phase agreement count. It sits between the oscillator array and the host/control logic. It takes asynchronous `out` signals from the oscillator cells and returns a registered spin vector through a valid/ready handshake.

---
 rtl/ising_pkg.sv | 20 ++
 rtl/osc_phase_reader_if.sv | 22 ++
 rtl/osc_sync.sv | 21 ++
 rtl/osc_phase_reader.sv | 88 ++++++++
 tb/tb_osc_phase_reader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ising_pkg.sv
// Shared definitions for the Ising array readout path: FSM states,
// synchronizer depth and the spin decode rule.
package ising_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      DONE
   } state_t;

   localparam int SYNC_DEPTH    = 2;
   localparam int SETTLE_CYCLES = SYNC_DEPTH;

   // Strict majority of in-phase samples; an exact tie reads as anti-phase.
   function automatic logic spin_decode(int unsigned cnt, int unsigned window);
      return (2 * cnt) > window;
   endfunction

endpackage

// File: rtl/osc_phase_reader_if.sv
// Host-side request/result handshake of the oscillator phase reader.
interface osc_phase_reader_if #(
   parameter int N     = 4,
   parameter int CNT_W = 9
);
   logic               start;
   logic               busy;
   logic               spins_valid;
   logic               spins_ready;
   logic [N-1:0]       spins;
   logic [N*CNT_W-1:0] agree_cnt;

   modport master (
      output start, spins_ready,
      input  busy, spins_valid, spins, agree_cnt
   );

   modport slave (
      input  start, spins_ready,
      output busy, spins_valid, spins, agree_cnt
   );
endinterface

// File: rtl/osc_sync.sv
// Two-flop synchronizer bank for asynchronous oscillator outputs.
module osc_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/osc_phase_reader.sv
// Counts per-oscillator phase agreement with oscillator 0 over a fixed
// window and publishes the decoded spin vector through a valid/ready handshake.
module osc_phase_reader
   import ising_pkg::*;
#(
   parameter int N      = 4,
   parameter int WINDOW = 256,
   parameter int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] osc_in,
   osc_phase_reader_if.slave bus
);
   logic [N-1:0]       osc_s;
   state_t             state;
   logic [1:0]         settle_cnt;
   logic [CNT_W-1:0]   sample_cnt;
   logic [CNT_W-1:0]   cnt [N];
   logic               busy_q;
   logic               valid_q;
   logic [N-1:0]       spins_q;
   logic [N*CNT_W-1:0] agree_q;

   osc_sync #(.WIDTH(N)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (osc_in),
      .q   (osc_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         sample_cnt <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         spins_q    <= '0;
         agree_q    <= '0;
         for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= SETTLE;
                  busy_q     <= 1'b1;
                  settle_cnt <= '0;
                  sample_cnt <= '0;
                  for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
               end
            end
            SETTLE: begin
               if (settle_cnt == 2'(SETTLE_CYCLES - 1)) state <= MEASURE;
               else settle_cnt <= settle_cnt + 2'd1;
            end
            MEASURE: begin
               // WINDOW counting cycles, then one extra cycle to register the result.
               if (sample_cnt != CNT_W'(WINDOW)) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  for (int unsigned i = 0; i < N; i++)
                     cnt[i] <= cnt[i] + CNT_W'(osc_s[i] == osc_s[0]);
               end else begin
                  for (int unsigned i = 0; i < N; i++) begin
                     agree_q[i*CNT_W +: CNT_W] <= cnt[i];
                     spins_q[i] <= spin_decode(int'(cnt[i]), WINDOW);
                  end
                  valid_q <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (bus.spins_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.spins_valid = valid_q;
   assign bus.spins       = spins_q;
   assign bus.agree_cnt   = agree_q;
endmodule

// File: tb/tb_osc_phase_reader.sv
// Self-checking bench for osc_phase_reader: fixed phase patterns from a table
// plus randomized oscillator streams checked against a sample-counting model.
module tb_osc_phase_reader;
   localparam int N  = 4;
   localparam int W  = 256;
   localparam int CW = $clog2(W + 1);

   typedef struct {
      string           name;
      int              kind;
      bit              poke;
      logic [N-1:0]    spins;
      logic [N*CW-1:0] cnts;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] osc = '0;

   osc_phase_reader_if #(.N(N), .CNT_W(CW)) bus ();

   osc_phase_reader #(.N(N), .WINDOW(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .osc_in (osc),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;
   int unsigned  pr [N];
   logic [N-1:0] samp [W + 16];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Oscillator value presented to the next clock edge.
   function automatic logic [N-1:0] gen(input int kind);
      logic [N-1:0] v;
      logic         b;
      logic         q;
      v = '0;
      b = ((cyc % 10) < 5);
      case (kind)
         0: v = {N{b}};
         1: begin
            v    = {N{b}};
            v[1] = ~b;
         end
         2: begin
            b = ((cyc % 8) < 4);
            q = (((cyc + 6) % 8) < 4);
            v = {q, 1'b0, b, b};
         end
         default: begin
            b    = 1'($urandom_range(0, 1));
            v[0] = b;
            for (int i = 1; i < N; i++)
               v[i] = (kind == 3) ? 1'($urandom_range(0, 1))
                                  : (b ^ (32'($urandom_range(0, 255)) < pr[i]));
         end
      endcase
      return v;
   endfunction

   // Sample at edge k (k = 1..W after the start edge) is what gets counted.
   function automatic void model(output logic [N-1:0] sp, output logic [N*CW-1:0] ac);
      int c;
      sp = '0;
      ac = '0;
      for (int i = 0; i < N; i++) begin
         c = 0;
         for (int k = 1; k <= W; k++)
            if (samp[k][i] == samp[k][0]) c++;
         sp[i] = (2 * c > W);
         ac[i*CW +: CW] = CW'(c);
      end
   endfunction

   task automatic run(input string nm, input int kind, input bit poke, input bit ready_early,
                      output int lat, output logic [N-1:0] esp, output logic [N*CW-1:0] eac);
      lat             = -1;
      bus.spins_ready = ready_early;
      bus.start       = 1'b1;
      osc             = gen(kind);
      samp[0]         = osc;
      tick();
      chk({nm, "_busy_rise"}, 64'(bus.busy), 64'd1);
      for (int e = 1; e <= W + 10; e++) begin
         bus.start = poke && (e == 1 || e == 2 || e == 50 || e == W);
         osc       = gen(kind);
         samp[e]   = osc;
         tick();
         if (bus.spins_valid) begin
            lat = e;
            break;
         end
      end
      bus.start = 1'b0;
      chk({nm, "_latency"}, 64'(lat), 64'(W + 3));
      model(esp, eac);
      chk({nm, "_spins_model"}, 64'(bus.spins), 64'(esp));
      for (int i = 0; i < N; i++)
         chk($sformatf("%s_cnt%0d_model", nm, i), 64'(bus.agree_cnt[i*CW +: CW]),
             64'(eac[i*CW +: CW]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t            vecs [3];
      int              lat;
      logic [N-1:0]    esp;
      logic [N*CW-1:0] eac;

      vecs[0] = '{"inphase", 0, 1'b1, 4'b1111, {9'd256, 9'd256, 9'd256, 9'd256}};
      vecs[1] = '{"antiphase", 1, 1'b0, 4'b1101, {9'd256, 9'd256, 9'd0, 9'd256}};
      vecs[2] = '{"tie_quad", 2, 1'b0, 4'b0011, {9'd128, 9'd128, 9'd256, 9'd256}};
      for (int i = 0; i < N; i++) pr[i] = 0;

      bus.start       = 1'b0;
      bus.spins_ready = 1'b0;
      rst             = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_valid", 64'(bus.spins_valid), 64'd0);
      chk("rst_spins", 64'(bus.spins), 64'd0);
      chk("rst_cnt", 64'(bus.agree_cnt), 64'd0);

      foreach (vecs[v]) begin
         run(vecs[v].name, vecs[v].kind, vecs[v].poke, 1'b0, lat, esp, eac);
         chk({vecs[v].name, "_spins"}, 64'(bus.spins), 64'(vecs[v].spins));
         chk({vecs[v].name, "_cnts"}, 64'(bus.agree_cnt), 64'(vecs[v].cnts));
         bus.spins_ready = 1'b1;
         tick();
         bus.spins_ready = 1'b0;
         chk({vecs[v].name, "_valid_fall"}, 64'(bus.spins_valid), 64'd0);
         chk({vecs[v].name, "_busy_fall"}, 64'(bus.busy), 64'd0);
         chk({vecs[v].name, "_hold_spins"}, 64'(bus.spins), 64'(vecs[v].spins));
      end

      // Backpressure with an ignored start, then a start on the handshake edge.
      run("bp", 3, 1'b0, 1'b0, lat, esp, eac);
      for (int c = 0; c < 20; c++) begin
         bus.start = (c == 5);
         tick();
         chk("bp_valid", 64'(bus.spins_valid), 64'd1);
         chk("bp_busy", 64'(bus.busy), 64'd1);
         chk("bp_spins", 64'(bus.spins), 64'(esp));
         chk("bp_cnts", 64'(bus.agree_cnt), 64'(eac));
      end
      bus.spins_ready = 1'b1;
      bus.start       = 1'b1;
      tick();
      bus.spins_ready = 1'b0;
      chk("bp_hs_valid", 64'(bus.spins_valid), 64'd0);
      chk("bp_hs_busy", 64'(bus.busy), 64'd0);

      // Immediate restart; ready already high so DONE lasts one cycle.
      for (int i = 1; i < N; i++) pr[i] = $urandom_range(0, 255);
      run("early_rdy", 4, 1'b0, 1'b1, lat, esp, eac);
      tick();
      bus.spins_ready = 1'b0;
      chk("early_rdy_valid", 64'(bus.spins_valid), 64'd0);
      chk("early_rdy_busy", 64'(bus.busy), 64'd0);

      // Reset at edge 100 of a measurement.
      bus.start = 1'b1;
      osc       = gen(3);
      tick();
      bus.start = 1'b0;
      for (int e = 1; e < 100; e++) begin
         osc = gen(3);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_valid", 64'(bus.spins_valid), 64'd0);
      chk("midrst_spins", 64'(bus.spins), 64'd0);
      chk("midrst_cnt", 64'(bus.agree_cnt), 64'd0);
      tick();
      chk("midrst_idle_valid", 64'(bus.spins_valid), 64'd0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 1; i < N; i++) pr[i] = $urandom_range(0, 255);
         run($sformatf("rand%0d", r), 3 + (r % 2), r == 2, 1'b0, lat, esp, eac);
         bus.spins_ready = 1'b1;
         tick();
         bus.spins_ready = 1'b0;
         chk("rand_valid_fall", 64'(bus.spins_valid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
